muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and HI/LO register width.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request strobe, sampled on clk rising edge.
REQ-005 SHALL have port op, input, 2 bits: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
REQ-006 SHALL have port rs_val, input, WIDTH: multiplicand, dividend, or MTHI/MTLO source.
REQ-007 SHALL have port rt_val, input, WIDTH: multiplier or divisor.
REQ-008 SHALL have port busy, output, 1 bit: high while an iterative operation runs.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when hi/lo hold a new MULTU/DIVU result.
REQ-010 SHALL have ports hi and lo, outputs, WIDTH each: architectural HI/LO registers, read by the downstream MFHI/MFLO path.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and FIN.
- IDLE -> RUN on start with op=MULTU/DIVU.
- RUN -> FIN after exactly WIDTH iterations.
- FIN -> IDLE after one cycle.
REQ-012 SHALL accept start only in IDLE or FIN; start while in RUN SHALL be ignored, with no effect on state, hi or lo.
REQ-013 SHALL latch rs_val and rt_val into internal operand registers at the accepting edge; later input changes SHALL NOT affect the result.
REQ-014 SHALL drive busy=1 exactly while in RUN and done=1 exactly while in FIN.
REQ-015 SHALL complete in fixed latency: start accepted at edge N -> hi/lo updated at edge N+WIDTH -> done high during the following cycle.
REQ-016 SHALL implement MULTU as unsigned shift-add, one bit per cycle, producing a 2*WIDTH product: hi = upper half, lo = lower half.
REQ-017 SHALL implement DIVU as unsigned restoring division, one quotient bit per cycle: lo = quotient, hi = remainder.
REQ-018 SHALL, for DIVU with divisor 0, produce lo = all ones and hi = dividend with the same latency; no exception SHALL be raised.
REQ-019 SHALL leave hi/lo unchanged during RUN and update both atomically at the RUN->FIN edge.
REQ-020 SHALL execute MTHI/MTLO on an accepted start in a single cycle: write rs_val to hi or lo, leave the other register unchanged, keep busy=0 and done=0.
REQ-021 SHALL, when start arrives in FIN, accept the new operation at that edge (back-to-back); done SHALL still pulse for exactly one cycle.
REQ-022 SHALL hold hi/lo stable in IDLE indefinitely.

Reset
REQ-023 SHALL, on rst_n low, immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0 and operand registers=0, independent of clk.
REQ-024 SHALL abort any in-progress operation on reset mid-RUN, discard the partial result and leave hi/lo at 0 after rst_n deasserts.
REQ-025 SHALL ignore start on the first edge at which rst_n is low; after deassertion, the first rising edge SHALL be able to accept start.

Structure
REQ-026 SHALL place the op encodings, the FSM state enumeration and the WIDTH default in shared package muldiv_pkg.
REQ-027 SHALL isolate one combinational iteration step (add-or-skip for MULTU, subtract-or-restore for DIVU) in sub-module muldiv_step; counter, FSM and HI/LO registers SHALL remain in muldiv_unit.
REQ-028 SHALL use a counter of clog2(WIDTH)+1 bits and SHALL NOT wrap during RUN.

Verification
REQ-029 SHALL cover: MULTU 7 x 6 -> busy for 32 cycles, then hi=0x00000000, lo=0x0000002A, done pulses once 32 edges after accept.
REQ-030 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 SHALL cover: DIVU 100 / 7 -> lo=14, hi=2; then DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5.
REQ-032 SHALL cover: start with DIVU 9 / 3 pulsed at RUN cycle 10 of MULTU 3 x 4 -> ignored, result hi=0, lo=12, single done pulse.
REQ-033 SHALL cover: MTHI 0x1234 then MTLO 0xABCD in consecutive cycles -> hi=0x1234, lo=0xABCD, busy and done never asserted.
REQ-034 SHALL cover: rst_n low at RUN cycle 15 of DIVU 100 / 7 -> busy, done, hi and lo all 0 asynchronously; a new MULTU 2 x 3 after release -> lo=6.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MTHI  = 2'b10,
    OP_MTLO  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: shift-add multiply or restoring divide.
// {acc, aux} is the working pair: product for MULTU, {remainder, quotient} for DIVU.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] aux,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_next_c,
  output logic [WIDTH-1:0] aux_next_c
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_sub;
  logic             ge;

  // Add-or-skip then shift right (MULTU); shift left then subtract-or-restore (DIVU).
  // The subtraction is taken modulo 2^WIDTH: when it is kept the true result is below the divisor.
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, (aux[0] ? opnd : {WIDTH{1'b0}})};
    shifted = {acc, aux[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd});
    rem_sub = shifted[WIDTH-1:0] - opnd;
    if (is_div) begin
      acc_next_c = ge ? rem_sub : shifted[WIDTH-1:0];
      aux_next_c = {aux[WIDTH-2:0], ge};
    end else begin
      acc_next_c = sum[WIDTH:1];
      aux_next_c = {sum[0], aux[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULTU/DIVU unit with architectural HI/LO registers and MTHI/MTLO writes.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] aux;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_next_c;
  logic [WIDTH-1:0] aux_next_c;
  logic             accept_c;
  op_e              op_c;

  assign op_c     = op_e'(op);
  assign accept_c = start && (state != ST_RUN);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div     (is_div),
    .acc        (acc),
    .aux        (aux),
    .opnd       (opnd),
    .acc_next_c (acc_next_c),
    .aux_next_c (aux_next_c)
  );

  // FSM, iteration counter, operand latches and HI/LO; hi/lo only change at RUN->FIN or on MTHI/MTLO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      acc    <= '0;
      aux    <= '0;
      opnd   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          acc <= acc_next_c;
          aux <= aux_next_c;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            hi    <= acc_next_c;
            lo    <= aux_next_c;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          done  <= 1'b0;
          state <= ST_IDLE;
          if (accept_c) begin
            case (op_c)
              OP_MULTU, OP_DIVU: begin
                is_div <= (op_c == OP_DIVU);
                acc    <= '0;
                aux    <= rs_val;
                opnd   <= rt_val;
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= ST_RUN;
              end
              OP_MTHI: hi <= rs_val;
              default: lo <= rs_val;
            endcase
          end
        end
      endcase
    end
  end

endmodule
